vector_serializer: RTL and testbench
====================================

VECTOR_SERIALIZER -- requirements
Module: vector_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one vector element (FP16 encoding).
REQ-002 Parameter LENGTH, default 4, number of elements per vector (>= 2).
REQ-003 Parameter CAPTURE_DELAY, default 2, cycles from start to vector capture, matching vector-adder output latency (>= 0).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle strobe; the adder inputs for a new vector were applied this cycle.
REQ-007 In_vec  input  DATA_WIDTH x [0:LENGTH-1]  parallel vector from the vector adder Out port.
REQ-008 out_data  output  DATA_WIDTH  current serialized element.
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_ready  input  1  downstream accepts the element when out_valid && out_ready.
REQ-011 out_last  output  1  high with out_valid on element LENGTH-1.
REQ-012 out_idx  output  $clog2(LENGTH)  index of the current element.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 overrun  output  1  sticky; start received while busy.

Function
REQ-015 FSM states: IDLE, WAIT, STREAM.
REQ-016 IDLE + start: go to WAIT and load the delay counter with CAPTURE_DELAY; with CAPTURE_DELAY=0, capture In_vec on the same edge and go directly to STREAM.
REQ-017 WAIT: decrement the counter once per cycle; on the edge where it reaches 0, capture all LENGTH elements of In_vec into an internal buffer, set idx=0, and go to STREAM.
REQ-018 Captured start-to-first-valid latency: out_valid rises exactly CAPTURE_DELAY+1 cycles after the start cycle.
REQ-019 STREAM: out_valid=1 and out_data=buffer[idx]; on a handshake, idx increments; idx never changes without a handshake.
REQ-020 out_data, out_idx and out_last hold stable while out_valid && !out_ready.
REQ-021 Handshake with idx=LENGTH-1 (out_last=1): return to IDLE; out_valid is low the next cycle.
REQ-022 Maximum throughput: one element per cycle when out_ready is held high; LENGTH consecutive valid cycles.
REQ-023 start while busy (WAIT or STREAM): ignored, no change to state, buffer or counter; overrun set to 1.
REQ-024 start in the same cycle as the final handshake: treated as busy; ignored and flags overrun.
REQ-025 The buffer is written only on capture; In_vec changes after capture do not affect output.
REQ-026 out_data is 0 whenever out_valid=0.

Reset
REQ-027 reset forces IDLE, out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, overrun=0, counter=0, buffer cleared.
REQ-028 reset asserted mid-WAIT or mid-STREAM aborts the vector; the pending capture is discarded; reset takes priority over start.

Configuration
REQ-029 Macro VECTOR_SERIALIZER_RELU_EN: when defined, out_data is 0 for any element with sign bit [DATA_WIDTH-1]=1 and is the element otherwise; the buffer itself is unchanged.
REQ-030 Without VECTOR_SERIALIZER_RELU_EN, out_data passes buffer elements unmodified, including negative values.
REQ-031 The macro does not change handshake timing, out_last, out_idx or latency.

Verification
REQ-032 LENGTH=4, CAPTURE_DELAY=2, out_ready=1; start at cycle 0 with In_vec={3C00,4000,4200,4400} -> out_valid cycles 3..6, data 3C00,4000,4200,4400, out_last only at cycle 6, busy low at cycle 7.
REQ-033 Same vector, out_ready low for cycles 4-5 -> element 4000 held stable cycles 4-6; out_last at cycle 8.
REQ-034 start again at cycle 4 while streaming -> overrun=1 and stays 1; the stream is unaltered; no second vector is emitted.
REQ-035 reset pulse at cycle 4 -> cycle 5: out_valid=0, busy=0, overrun=0; a new start then streams normally.
REQ-036 With VECTOR_SERIALIZER_RELU_EN, In_vec={BC00,4000,C200,0000} -> outputs 0000,4000,0000,0000; without it, outputs BC00,4000,C200,0000.
REQ-037 CAPTURE_DELAY=0, start with out_ready=1 -> out_valid rises on the next cycle with element 0; the captured In_vec is the value present in the start cycle.

Source files
------------

// File: rtl/vector_serializer.sv
// vector_serializer
//   Captures a parallel vector from the vector adder CAPTURE_DELAY cycles
//   after a start strobe, then streams its elements out one at a time over
//   a valid/ready handshake.
//
// Configuration macro: VECTOR_SERIALIZER_RELU_EN
//   When defined, elements with the sign bit set are presented as zero on
//   out_data. The buffer contents, handshake timing, out_last and out_idx
//   are unaffected.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   strobe: adder inputs for a new vector applied this cycle
//   In_vec     in   DATA_WIDTH x [0:LENGTH-1] parallel vector from the adder
//   out_data   out  current element (0 when out_valid is low)
//   out_valid  out  out_data holds a valid element
//   out_ready  in   downstream accepts when out_valid && out_ready
//   out_last   out  high with out_valid on element LENGTH-1
//   out_idx    out  index of the current element
//   busy       out  high whenever not IDLE
//   overrun    out  sticky: start seen while busy
module vector_serializer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned LENGTH        = 4,
    parameter int unsigned CAPTURE_DELAY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [DATA_WIDTH-1:0]       In_vec [0:LENGTH-1],
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [$clog2(LENGTH)-1:0]   out_idx,
    output logic                        busy,
    output logic                        overrun
);

    localparam int unsigned IDX_W = $clog2(LENGTH);
    localparam int unsigned CNT_W = (CAPTURE_DELAY > 0) ? $clog2(CAPTURE_DELAY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]   buf_q [0:LENGTH-1];
    logic [DATA_WIDTH-1:0]   buf_d [0:LENGTH-1];
    logic [DATA_WIDTH-1:0]   elem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        buf_d     = buf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (CAPTURE_DELAY == 0) begin
                        // Zero delay: the adder output is already valid now.
                        buf_d   = In_vec;
                        idx_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        cnt_d   = CNT_W'(CAPTURE_DELAY);
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (start) begin
                    overrun_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                // Capture on the edge where the counter reaches zero.
                if (cnt_q == CNT_W'(1)) begin
                    buf_d   = In_vec;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end

            S_STREAM: begin
                // A start here, including on the final handshake, is dropped.
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < LENGTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            buf_q     <= buf_d;
        end
    end

    assign elem      = buf_q[idx_q];
    assign out_valid = (state_q == S_STREAM);
    assign busy      = (state_q != S_IDLE);
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign overrun   = overrun_q;

`ifdef VECTOR_SERIALIZER_RELU_EN
    assign out_data = (out_valid && !elem[DATA_WIDTH-1]) ? elem : '0;
`else
    assign out_data = out_valid ? elem : '0;
`endif

endmodule

// File: tb/tb_vector_serializer.sv
// Self-checking bench for vector_serializer: one instance with
// CAPTURE_DELAY=2 and one with CAPTURE_DELAY=0, scoreboard-based data checks
// plus per-cycle valid/last/busy/overrun expectations.
module tb_vector_serializer;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready0 = 1'b1;
    logic [15:0] in_vec  [0:3];
    logic [15:0] in_vec0 [0:3];

    logic [15:0] out_data, out_data0;
    logic        out_valid, out_valid0;
    logic        out_last, out_last0;
    logic [1:0]  out_idx, out_idx0;
    logic        busy, busy0;
    logic        overrun, overrun0;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    exp_t q  [$];
    exp_t q0 [$];

    bit          held_v = 1'b0;
    logic [15:0] held_d;
    logic [1:0]  held_idx;
    logic        held_last;

    always #5 clk = ~clk;

    vector_serializer #(.DATA_WIDTH(16), .LENGTH(4), .CAPTURE_DELAY(2)) u_dut (
        .clk(clk), .reset(reset), .start(start), .In_vec(in_vec),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_idx(out_idx), .busy(busy), .overrun(overrun)
    );

    vector_serializer #(.DATA_WIDTH(16), .LENGTH(4), .CAPTURE_DELAY(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .In_vec(in_vec0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_last(out_last0), .out_idx(out_idx0), .busy(busy0), .overrun(overrun0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] x);
`ifdef VECTOR_SERIALIZER_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic push_expected(input logic [63:0] vec, input bit to_q0);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.d    = model_out(vec[63-16*i -: 16]);
            e.idx  = 2'(i);
            e.last = (i == 3);
            if (to_q0) q0.push_back(e);
            else       q.push_back(e);
        end
    endtask

    // Scoreboard pops and hold/idle-zero checks, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("sb_data", 32'(out_data), 32'(e.d));
                    check("sb_idx",  32'(out_idx),  32'(e.idx));
                    check("sb_last", 32'(out_last), 32'(e.last));
                end
            end
            if (!out_valid) check("data_zero_idle", 32'(out_data), 32'h0);
            if (held_v) begin
                check("hold_data", 32'(out_data), 32'(held_d));
                check("hold_idx",  32'(out_idx),  32'(held_idx));
                check("hold_last", 32'(out_last), 32'(held_last));
            end
            held_v    = out_valid && !out_ready && !reset;
            held_d    = out_data;
            held_idx  = out_idx;
            held_last = out_last;

            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) begin
                    check("sb0_unexpected_beat", 32'(out_data0), 32'hFFFF_FFFF);
                end else begin
                    e = q0.pop_front();
                    check("sb0_data", 32'(out_data0), 32'(e.d));
                    check("sb0_idx",  32'(out_idx0),  32'(e.idx));
                    check("sb0_last", 32'(out_last0), 32'(e.last));
                end
            end
            if (!out_valid0) check("data0_zero_idle", 32'(out_data0), 32'h0);
        end
    end

    task automatic reset_dut();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0; start0 = 1'b0;
        out_ready = 1'b1; out_ready0 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); q0.delete();
        @(negedge clk);
        mon_en = 1'b1;
        check("rst_valid",   32'(out_valid),  32'h0);
        check("rst_busy",    32'(busy),       32'h0);
        check("rst_overrun", 32'(overrun),    32'h0);
        check("rst_data",    32'(out_data),   32'h0);
        check("rst_idx",     32'(out_idx),    32'h0);
        check("rst_last",    32'(out_last),   32'h0);
        check("rst0_valid",  32'(out_valid0), 32'h0);
        check("rst0_busy",   32'(busy0),      32'h0);
    endtask

    // Start at cycle 0; optional stall window, second start and reset pulse.
    task automatic run_case(input string name, input logic [63:0] vec,
                            input int stall_lo, input int stall_hi,
                            input int start2_at, input int rst_at,
                            input int n_cyc, input int last_cyc, input bit expect_ovr);
        bit exp_valid, exp_last, exp_busy, exp_ovr;
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk); #1;
            start     = (c == 0) || (c == start2_at) || (c == rst_at);
            reset     = (c == rst_at);
            out_ready = !(c >= stall_lo && c <= stall_hi);
            for (int i = 0; i < 4; i++) begin
                in_vec[i] = (c <= 2) ? vec[63-16*i -: 16] : 16'($urandom);
            end
            if (c == 0) push_expected(vec, 1'b0);
            if (rst_at >= 0 && c == rst_at + 1) q.delete();
            @(negedge clk);
            if (rst_at >= 0 && c > rst_at) begin
                exp_valid = 1'b0; exp_last = 1'b0; exp_busy = 1'b0; exp_ovr = 1'b0;
            end else begin
                exp_valid = (c >= 3 && c <= last_cyc);
                exp_last  = (c == last_cyc);
                exp_busy  = (c >= 1 && c <= last_cyc);
                exp_ovr   = expect_ovr && start2_at >= 0 && c > start2_at;
            end
            check($sformatf("%s_valid_c%0d", name, c),   32'(out_valid), 32'(exp_valid));
            check($sformatf("%s_last_c%0d", name, c),    32'(out_last),  32'(exp_last));
            check($sformatf("%s_busy_c%0d", name, c),    32'(busy),      32'(exp_busy));
            check($sformatf("%s_overrun_c%0d", name, c), 32'(overrun),   32'(exp_ovr));
        end
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0; out_ready = 1'b1;
        check($sformatf("%s_sb_empty", name), 32'(q.size()), 32'h0);
    endtask

    task automatic run_cd0(input string name, input logic [63:0] vec);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            start0 = (c == 0);
            for (int i = 0; i < 4; i++) begin
                in_vec0[i] = (c == 0) ? vec[63-16*i -: 16] : 16'($urandom);
            end
            if (c == 0) push_expected(vec, 1'b1);
            @(negedge clk);
            check($sformatf("%s_valid_c%0d", name, c), 32'(out_valid0), 32'(c >= 1 && c <= 4));
            check($sformatf("%s_last_c%0d", name, c),  32'(out_last0),  32'(c == 4));
            check($sformatf("%s_busy_c%0d", name, c),  32'(busy0),      32'(c >= 1 && c <= 4));
        end
        check($sformatf("%s_sb_empty", name), 32'(q0.size()), 32'h0);
    endtask

    initial begin
        logic [63:0] vec_a, vec_b, vec_n;
        vec_a = 64'h3C00_4000_4200_4400;
        vec_b = 64'h1234_8001_7FFF_0042;
        vec_n = 64'hBC00_4000_C200_0000;
        for (int i = 0; i < 4; i++) begin
            in_vec[i] = '0; in_vec0[i] = '0;
        end

        reset_dut();
        run_case("basic", vec_a, -1, -1, -1, -1, 9, 6, 1'b0);
        reset_dut();
        run_case("stall", vec_a, 4, 5, -1, -1, 11, 8, 1'b0);
        reset_dut();
        run_case("ovr_mid", vec_a, -1, -1, 4, -1, 9, 6, 1'b1);
        reset_dut();
        run_case("ovr_final", vec_a, -1, -1, 6, -1, 9, 6, 1'b1);
        reset_dut();
        run_case("rst_mid", vec_a, -1, -1, -1, 4, 7, 6, 1'b0);
        run_case("after_rst", vec_b, -1, -1, -1, -1, 9, 6, 1'b0);
        reset_dut();
        run_case("neg", vec_n, -1, -1, -1, -1, 9, 6, 1'b0);
        reset_dut();
        run_cd0("cd0_a", vec_a);
        run_cd0("cd0_neg", vec_n);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
